rf_operand_fetch: RTL
=====================

// Module: rf_operand_fetch
// PURPOSE
//  Requester-side controller for the 2-read/1-write register file (rf_* ports connect to it).
//  - Accepts decoded operand requests (rs, rt, rd) on a valid/ready handshake.
//  - Drives the RF read pointers and absorbs the RF's one-cycle registered read latency.
//  - Presents the operand pair downstream on a valid/ready handshake.
//  - Routes writeback into the RF write port and forwards in-flight writebacks, so operands
//    never carry stale register values.
// PARAMETERS
//  ADDR_W  4  register address width (2**ADDR_W registers)
//  DATA_W  8  register data width
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst_n          in   1       asynchronous, active-low reset
//  req_valid      in   1       operand request valid
//  req_ready      out  1       request accepted when req_valid && req_ready at posedge
//  req_rs         in   ADDR_W  source register A
//  req_rt         in   ADDR_W  source register B
//  req_rd         in   ADDR_W  destination tag, passed through unchanged
//  rf_read0_addr  out  ADDR_W  RF read pointer 0 (rs)
//  rf_read1_addr  out  ADDR_W  RF read pointer 1 (rt)
//  rf_read0_val   in   DATA_W  RF read data 0; valid the cycle after its address is sampled
//  rf_read1_val   in   DATA_W  RF read data 1
//  rf_write_addr  out  ADDR_W  RF write pointer
//  rf_wen         out  1       RF write enable
//  rf_write_data  out  DATA_W  RF write data
//  wb_valid       in   1       writeback valid; always accepted, no backpressure
//  wb_addr        in   ADDR_W  writeback register
//  wb_data        in   DATA_W  writeback data
//  op_valid       out  1       operand bundle valid
//  op_ready       in   1       downstream accepts when op_valid && op_ready at posedge
//  op_a           out  DATA_W  value of rs
//  op_b           out  DATA_W  value of rt
//  op_rd          out  ADDR_W  captured req_rd
// BEHAVIOUR
//  - FSM states: IDLE, WAIT, VALID. Reset state is IDLE.
//    - IDLE  -> WAIT   on accept.
//    - WAIT  -> VALID  always, after 1 cycle.
//    - VALID -> IDLE   on op fire with no new accept.
//    - VALID -> WAIT   on op fire with a simultaneous accept.
//    - VALID holds otherwise.
//  - req_ready = (state==IDLE) || (state==VALID && op_ready). Combinational; never depends on
//    req_valid.
//  - Read pointers:
//    - rf_read*_addr = req_rs/req_rt when req_ready=1.
//    - Otherwise they are the registered rs_q/rt_q.
//    - The RF samples them at the accept edge.
//  - Latency: accept at edge N; RF data valid in the WAIT cycle; op_* registered at edge N+1;
//    op_valid high after N+1. Peak throughput is 1 request per 2 cycles.
//  - Writeback path is combinational, zero latency: rf_wen = wb_valid,
//    rf_write_addr = wb_addr, rf_write_data = wb_data.
//  - Forwarding applies per operand; rs and rt are compared independently.
//    - Accept cycle: the RF returns the old value on a same-edge write. If wb_valid and
//      wb_addr == req_rs, set fwd_a and latch wb_data. Same rule for rt.
//    - WAIT cycle: if wb_valid and wb_addr == rs_q, capture wb_data into op_a instead of the
//      RF value. Otherwise capture the forwarded value if fwd_a is set, else rf_read0_val.
//    - VALID and not firing: if wb_valid and wb_addr == rs_q, update op_a to wb_data next
//      cycle. Same rule for op_b.
//  - Held outputs: op_a, op_b and op_rd stay stable while op_valid && !op_ready, except for
//    forwarding updates.
//  - op_* outside VALID: value is don't-care; op_valid = 0.
//  - Reset (async assert, any state): state goes to IDLE; op_valid, op_a, op_b, op_rd, rs_q,
//    rt_q, fwd flags are all 0. req_ready = 1 during and after reset. An in-flight request
//    is dropped.
// TESTING
//  - Basic fetch: preload R3=0x12, R5=0x34; accept rs=3, rt=5, rd=7 at edge N
//    -> op_valid=1 after N+1, op_a=0x12, op_b=0x34, op_rd=7.
//  - Accept-edge forward: as above, plus wb R3=0xAA in the accept cycle -> op_a=0xAA,
//    op_b=0x34.
//  - Stall forward: op_ready=0 for 3 cycles in VALID; wb R5=0x55 in the 2nd cycle
//    -> op_b=0x55 from the next cycle; op_a unchanged; fires on op_ready=1.
//  - Back-to-back: op_ready=1 and req_valid=1 in VALID -> both fire; 1 WAIT cycle with
//    op_valid=0; new bundle valid one edge later.
//  - rs==rt=4 with wb R4=0x99 in WAIT -> op_a = op_b = 0x99.
//  - Reset: rst_n low mid-WAIT -> op_valid=0 immediately; req_ready=1; after release a
//    fresh request fetches correctly.

Source files
------------

// File: rtl/rf_operand_fetch_if.sv
// Operand-fetch bus: request, register-file ports, writeback and operand bundle.
// slave is the fetch controller's view; master is the surrounding pipeline/RF view.
interface rf_operand_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;
    logic [ADDR_W-1:0] req_rd;

    logic [ADDR_W-1:0] rf_read0_addr;
    logic [ADDR_W-1:0] rf_read1_addr;
    logic [DATA_W-1:0] rf_read0_val;
    logic [DATA_W-1:0] rf_read1_val;
    logic [ADDR_W-1:0] rf_write_addr;
    logic              rf_wen;
    logic [DATA_W-1:0] rf_write_data;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] op_rd;

    modport slave (
        input  req_valid, req_rs, req_rt, req_rd,
        output req_ready,
        output rf_read0_addr, rf_read1_addr, rf_write_addr, rf_wen, rf_write_data,
        input  rf_read0_val, rf_read1_val,
        input  wb_valid, wb_addr, wb_data,
        output op_valid, op_a, op_b, op_rd,
        input  op_ready
    );

    modport master (
        output req_valid, req_rs, req_rt, req_rd,
        input  req_ready,
        input  rf_read0_addr, rf_read1_addr, rf_write_addr, rf_wen, rf_write_data,
        output rf_read0_val, rf_read1_val,
        output wb_valid, wb_addr, wb_data,
        input  op_valid, op_a, op_b, op_rd,
        output op_ready
    );
endinterface

// File: rtl/rf_operand_fetch.sv
// Operand fetch controller for a 2R/1W register file with one-cycle registered reads.
// Forwards writebacks at every point a fetched operand could otherwise go stale.
module rf_operand_fetch #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_operand_fetch_if.slave    bus
);
    // state   | meaning
    // S_IDLE  | no request held; ready to accept
    // S_WAIT  | RF read in flight; operands captured at the next edge
    // S_VALID | operand bundle presented downstream
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic              fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [DATA_W-1:0] fwd_a_data_q, fwd_a_data_d, fwd_b_data_q, fwd_b_data_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ADDR_W-1:0] op_rd_q, op_rd_d;

    logic req_ready, req_fire, op_fire;
    logic wb_hit_a, wb_hit_b;

    assign req_ready = (state_q == S_IDLE) || ((state_q == S_VALID) && bus.op_ready);
    assign req_fire  = bus.req_valid && req_ready;
    assign op_fire   = (state_q == S_VALID) && bus.op_ready;
    assign wb_hit_a  = bus.wb_valid && (bus.wb_addr == rs_q);
    assign wb_hit_b  = bus.wb_valid && (bus.wb_addr == rt_q);

    assign bus.req_ready     = req_ready;
    assign bus.rf_read0_addr = req_ready ? bus.req_rs : rs_q;
    assign bus.rf_read1_addr = req_ready ? bus.req_rt : rt_q;
    assign bus.rf_wen        = bus.wb_valid;
    assign bus.rf_write_addr = bus.wb_addr;
    assign bus.rf_write_data = bus.wb_data;
    assign bus.op_valid      = (state_q == S_VALID);
    assign bus.op_a          = op_a_q;
    assign bus.op_b          = op_b_q;
    assign bus.op_rd         = op_rd_q;

    always_comb begin
        state_d      = state_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        fwd_a_data_d = fwd_a_data_q;
        fwd_b_data_d = fwd_b_data_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_rd_d      = op_rd_q;

        case (state_q)
            S_IDLE: if (req_fire) state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_VALID;
                op_a_d  = wb_hit_a ? bus.wb_data : (fwd_a_q ? fwd_a_data_q : bus.rf_read0_val);
                op_b_d  = wb_hit_b ? bus.wb_data : (fwd_b_q ? fwd_b_data_q : bus.rf_read1_val);
                op_rd_d = rd_q;
            end
            S_VALID: begin
                if (op_fire) begin
                    state_d = req_fire ? S_WAIT : S_IDLE;
                end else begin
                    if (wb_hit_a) op_a_d = bus.wb_data;
                    if (wb_hit_b) op_b_d = bus.wb_data;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The RF returns the pre-write value for a write landing on the accept edge.
        if (req_fire) begin
            rs_d         = bus.req_rs;
            rt_d         = bus.req_rt;
            rd_d         = bus.req_rd;
            fwd_a_d      = bus.wb_valid && (bus.wb_addr == bus.req_rs);
            fwd_b_d      = bus.wb_valid && (bus.wb_addr == bus.req_rt);
            fwd_a_data_d = bus.wb_data;
            fwd_b_data_d = bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_a_data_q <= '0;
            fwd_b_data_q <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_rd_q      <= '0;
        end else begin
            state_q      <= state_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            fwd_a_data_q <= fwd_a_data_d;
            fwd_b_data_q <= fwd_b_data_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_rd_q      <= op_rd_d;
        end
    end
endmodule
